// File: rtl/fifo_serial_pkg.sv
// Shared types and helpers for the FIFO-fed serial transmitter.
// State encoding is 3 bits; the parity helper is even parity over a zero-extended word.
package fifo_serial_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StPop    = 3'd1,
    StLoad   = 3'd2,
    StStart  = 3'd3,
    StData   = 3'd4,
    StParity = 3'd5,
    StStop   = 3'd6
  } tx_state_e;

  // Even parity bit: XOR of all data bits (callers zero-extend narrower words).
  function automatic logic even_parity(input logic [63:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter with synchronous clear; tick marks the last cycle of each bit period.
// tick_next lets the parent register outputs that must line up with the tick cycle.
module baud_tick_gen #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick,
  output logic tick_next
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clear || (cnt_q == CntMax)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick      = (cnt_q == CntMax);
  assign tick_next = (cnt_d == CntMax);

endmodule

// File: rtl/fifo_serial_tx.sv
// FIFO read-side consumer: pops one word at a time and sends it as a UART-style frame
// (start, DATA_W bits LSB-first, optional even parity, stop). All outputs are registered.
module fifo_serial_tx
  import fifo_serial_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned BitW = $clog2(DATA_W + 1);
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_W - 1);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              rd_en_q, rd_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              baud_clear, tick, tick_next;
  logic              start_ok;

  assign start_ok = enable && !fifo_empty;

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clear    (baud_clear),
    .tick     (tick),
    .tick_next(tick_next)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    par_d      = par_q;
    baud_clear = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_ok) state_d = StPop;
      end
      StPop: state_d = StLoad;
      StLoad: begin
        shift_d    = fifo_data;
        par_d      = even_parity(64'(fifo_data));
        bit_cnt_d  = '0;
        baud_clear = 1'b1;
        state_d    = StStart;
      end
      StStart: begin
        if (tick) state_d = StData;
      end
      StData: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LastBit) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_EN != 0) ? StParity : StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + BitW'(1);
          end
        end
      end
      StParity: begin
        if (tick) state_d = StStop;
      end
      StStop: begin
        // Back-to-back frames go straight to POP from the last stop cycle.
        if (tick) state_d = start_ok ? StPop : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are computed from the next state so they come straight from flops.
  always_comb begin
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
      StParity: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
    rd_en_d = (state_d == StPop);
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StStop) && tick_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
      rd_en_q   <= rd_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Directed bench: two transmitters (no parity / even parity), each fed by a small FIFO model.
// A serial receiver task rebuilds each frame and compares it against hand-computed bit vectors.
module tb_fifo_serial_tx;

  localparam int Cpb   = 4;
  localparam int Depth = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       en0 = 1'b0, en1 = 1'b0;
  logic       empty0, empty1, rd0, rd1, tx0, tx1, busy0, busy1, fd0, fd1;
  logic [7:0] dout0, dout1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rd_cnt0 = 0;
  int rd_cnt1 = 0;

  // FIFO models: registered read data, valid the cycle after a pop.
  logic [7:0] fmem [2][Depth];
  int         fcnt [2] = '{0, 0};
  int         fwp  [2] = '{0, 0};
  int         frp  [2] = '{0, 0};
  logic       fwr  [2] = '{1'b0, 1'b0};
  logic [7:0] fwd  [2] = '{8'h00, 8'h00};
  logic [7:0] fdout[2] = '{8'h00, 8'h00};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd0) rd_cnt0 <= rd_cnt0 + 1;
    if (rd1) rd_cnt1 <= rd_cnt1 + 1;
    for (int k = 0; k < 2; k++) begin
      if (fwr[k] && fcnt[k] < Depth) begin
        fmem[k][fwp[k]] <= fwd[k];
        fwp[k] <= (fwp[k] + 1) % Depth;
      end
      if (((k == 0) ? rd0 : rd1) && fcnt[k] > 0) begin
        fdout[k] <= fmem[k][frp[k]];
        frp[k] <= (frp[k] + 1) % Depth;
      end
      fcnt[k] <= fcnt[k] + ((fwr[k] && fcnt[k] < Depth) ? 1 : 0)
                 - ((((k == 0) ? rd0 : rd1) && fcnt[k] > 0) ? 1 : 0);
    end
  end

  assign empty0 = (fcnt[0] == 0);
  assign empty1 = (fcnt[1] == 0);
  assign dout0  = fdout[0];
  assign dout1  = fdout[1];

  fifo_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(Cpb), .PARITY_EN(0)) u_dut0 (
    .clk(clk), .rst(rst_n), .enable(en0), .fifo_empty(empty0), .fifo_data(dout0),
    .fifo_rd_en(rd0), .tx(tx0), .busy(busy0), .frame_done(fd0)
  );

  fifo_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(Cpb), .PARITY_EN(1)) u_dut1 (
    .clk(clk), .rst(rst_n), .enable(en1), .fifo_empty(empty1), .fifo_data(dout1),
    .fifo_rd_en(rd1), .tx(tx1), .busy(busy1), .frame_done(fd1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rd0 && empty0) check("rd_en_while_empty0", 1, 0);
    if (rd1 && empty1) check("rd_en_while_empty1", 1, 0);
  end

  task automatic fifo_write(input int k, input logic [7:0] d);
    fwr[k] = 1'b1;
    fwd[k] = d;
    @(negedge clk);
    fwr[k] = 1'b0;
  endtask

  // Waits for the start bit, samples every bit mid-period, and checks frame_done alignment.
  // Returns on the negedge of the last stop cycle.
  task automatic rx_frame(input int k, input int nbits, input bit drop_en,
                          output logic [10:0] bits, output int start);
    int w;
    bits  = '0;
    start = -1;
    w     = 0;
    do begin
      @(negedge clk);
      w++;
    end while (((k == 0) ? tx0 : tx1) !== 1'b0 && w < 400);
    if (w >= 400) begin
      check("rx_start_timeout", 0, 1);
      return;
    end
    start = cyc;
    repeat (2) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i > 0) repeat (Cpb) @(negedge clk);
      bits[i] = (k == 0) ? tx0 : tx1;
      if (drop_en && i == 4) en0 = 1'b0;
    end
    check("frame_done_early", (k == 0) ? fd0 : fd1, 0);
    @(negedge clk);
    check("frame_done_last_stop", (k == 0) ? fd0 : fd1, 1);
  endtask

  logic [7:0]  words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [10:0] bits;
  int          st, prev_st, c, r, w;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    repeat (2) @(negedge clk);
    check("rst_tx0", tx0, 1);
    check("rst_busy0", busy0, 0);
    check("rst_rd0", rd0, 0);
    check("rst_fd0", fd0, 0);
    check("rst_tx1", tx1, 1);
    check("rst_busy1", busy1, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_no_pop", rd_cnt0, 0);

    // Single byte A5: start falls 4 cycles after the write cycle
    en0 = 1'b1;
    c = cyc;
    r = rd_cnt0;
    fifo_write(0, 8'hA5);
    rx_frame(0, 10, 1'b0, bits, st);
    check("a5_bits", bits, {1'b0, 1'b1, 8'hA5, 1'b0});
    check("a5_latency", st, c + 4);
    @(negedge clk);
    check("a5_idle_busy", busy0, 0);
    check("a5_one_pop", rd_cnt0 - r, 1);
    check("a5_empty", empty0, 1);

    // Full FIFO, back-to-back frames with a 2-cycle gap
    en0 = 1'b0;
    r = rd_cnt0;
    for (int i = 0; i < 4; i++) fifo_write(0, words[i]);
    check("full_no_pop_disabled", rd_cnt0 - r, 0);
    en0 = 1'b1;
    prev_st = 0;
    for (int i = 0; i < 4; i++) begin
      rx_frame(0, 10, 1'b0, bits, st);
      check("full_word", bits, {1'b0, 1'b1, words[i], 1'b0});
      if (i > 0) check("full_gap", st, prev_st + 10 * Cpb + 2);
      prev_st = st;
    end
    @(negedge clk);
    check("full_idle_busy", busy0, 0);
    check("full_pop_count", rd_cnt0 - r, Depth);
    check("full_empty", empty0, 1);

    // Even parity, 11-bit frames
    fifo_write(1, 8'h07);
    fifo_write(1, 8'h03);
    en1 = 1'b1;
    rx_frame(1, 11, 1'b0, bits, st);
    check("par_07", bits, {1'b1, 1'b1, 8'h07, 1'b0});
    prev_st = st;
    rx_frame(1, 11, 1'b0, bits, st);
    check("par_03", bits, {1'b1, 1'b0, 8'h03, 1'b0});
    check("par_gap", st, prev_st + 11 * Cpb + 2);
    @(negedge clk);
    check("par_idle_busy", busy1, 0);
    check("par_pop_count", rd_cnt1, 2);

    // Enable dropped mid-frame
    en0 = 1'b0;
    r = rd_cnt0;
    fifo_write(0, 8'h5A);
    fifo_write(0, 8'hC3);
    fifo_write(0, 8'h81);
    en0 = 1'b1;
    rx_frame(0, 10, 1'b1, bits, st);
    check("drop_frame1", bits, {1'b0, 1'b1, 8'h5A, 1'b0});
    repeat (20) @(negedge clk);
    check("drop_one_pop", rd_cnt0 - r, 1);
    check("drop_remaining", fcnt[0], 2);
    check("drop_idle_busy", busy0, 0);
    en0 = 1'b1;
    rx_frame(0, 10, 1'b0, bits, st);
    check("drop_frame2", bits, {1'b0, 1'b1, 8'hC3, 1'b0});
    rx_frame(0, 10, 1'b0, bits, st);
    check("drop_frame3", bits, {1'b0, 1'b1, 8'h81, 1'b0});

    // Async reset in the middle of DATA; popped word is lost
    en0 = 1'b0;
    r = rd_cnt0;
    fifo_write(0, 8'h3C);
    fifo_write(0, 8'hE7);
    en0 = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (tx0 !== 1'b0 && w < 400);
    check("rst_mid_start_seen", (w < 400) ? 1 : 0, 1);
    repeat (10) @(negedge clk);
    check("rst_mid_busy_before", busy0, 1);
    check("rst_mid_tx_before", tx0, 0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx_async", tx0, 1);
    check("rst_mid_busy_async", busy0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rx_frame(0, 10, 1'b0, bits, st);
    check("rst_mid_next_frame", bits, {1'b0, 1'b1, 8'hE7, 1'b0});
    check("rst_mid_pop_count", rd_cnt0 - r, 2);
    @(negedge clk);
    check("rst_mid_idle_busy", busy0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
